// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with saturating direction counters and mispredict redirect
module branch_target_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_all,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_uncond,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_pc,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [STAT_W-1:0] stat_lookup_hits,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    logic              redirect_q;
    logic [ADDR_W-1:0] redirect_pc_q;
    logic [STAT_W-1:0] hits_q;
    logic [STAT_W-1:0] mispred_q;

    // Lookup reads the registered table only, so a same-cycle update is never visible here.
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    assign lk_idx     = lookup_pc[IDX_W+1:2];
    assign lk_tag     = lookup_pc[ADDR_W-1:IDX_W+2];
    assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken = lk_hit && ctr_q[lk_idx][CTR_W-1];
    assign pred_pc    = pred_taken ? target_q[lk_idx] : lookup_pc + ADDR_W'(4);

    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_hit;
    logic              up_taken_eff;
    logic [ADDR_W-1:0] actual_pc;
    logic              mispredict;

    assign up_idx       = upd_pc[IDX_W+1:2];
    assign up_tag       = upd_pc[ADDR_W-1:IDX_W+2];
    assign up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_taken_eff = upd_taken || upd_uncond;
    assign actual_pc    = upd_taken ? upd_target : upd_pc + ADDR_W'(4);
    assign mispredict   = upd_valid && (upd_pred_pc != actual_pc);

    // The predicted direction travels with the instruction for debug only; recovery compares PCs.
    logic unused_pred_taken;
    assign unused_pred_taken = upd_pred_taken;

    logic             ctr_we;
    logic             tgt_we;
    logic             alloc;
    logic [CTR_W-1:0] ctr_new;

    always_comb begin
        ctr_we  = 1'b0;
        tgt_we  = 1'b0;
        alloc   = 1'b0;
        ctr_new = ctr_q[up_idx];
        if (upd_valid && !flush_all) begin
            if (up_hit) begin
                ctr_we = 1'b1;
                if (upd_uncond) begin
                    ctr_new = CTR_MAX;
                    tgt_we  = 1'b1;
                end else if (upd_taken) begin
                    ctr_new = (ctr_q[up_idx] == CTR_MAX) ? CTR_MAX : ctr_q[up_idx] + CTR_W'(1);
                    tgt_we  = 1'b1;
                end else begin
                    ctr_new = (ctr_q[up_idx] == '0) ? '0 : ctr_q[up_idx] - CTR_W'(1);
                end
            end else if (up_taken_eff) begin
                ctr_we  = 1'b1;
                tgt_we  = 1'b1;
                alloc   = 1'b1;
                ctr_new = upd_uncond ? CTR_MAX : CTR_WEAK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else begin
            if (flush_all) begin
                valid_q <= '0;
            end else if (alloc) begin
                valid_q[up_idx] <= 1'b1;
            end
            if (alloc) begin
                tag_q[up_idx] <= up_tag;
            end
            if (tgt_we) begin
                target_q[up_idx] <= upd_target;
            end
            if (ctr_we) begin
                ctr_q[up_idx] <= ctr_new;
            end
        end
    end

    // Redirect pulses for exactly the cycle after a mispredict; the PC is held between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            hits_q        <= '0;
            mispred_q     <= '0;
        end else begin
            redirect_q <= mispredict;
            if (mispredict) begin
                redirect_pc_q <= actual_pc;
            end
            if (pred_taken && (hits_q != STAT_MAX)) begin
                hits_q <= hits_q + STAT_W'(1);
            end
            if (mispredict && (mispred_q != STAT_MAX)) begin
                mispred_q <= mispred_q + STAT_W'(1);
            end
        end
    end

    assign redirect         = redirect_q;
    assign redirect_pc      = redirect_pc_q;
    assign stat_lookup_hits = hits_q;
    assign stat_mispredicts = mispred_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - directed self-checking bench for branch_target_predictor
module tb_branch_target_predictor;

    localparam int AW = 32;
    localparam int SW = 4;

    logic          clk;
    logic          rst_n;
    logic          flush_all;
    logic [AW-1:0] lookup_pc;
    logic          pred_taken;
    logic [AW-1:0] pred_pc;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic          upd_uncond;
    logic          upd_taken;
    logic [AW-1:0] upd_target;
    logic          upd_pred_taken;
    logic [AW-1:0] upd_pred_pc;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [SW-1:0] stat_lookup_hits;
    logic [SW-1:0] stat_mispredicts;

    int n_cmp = 0;
    int n_err = 0;

    branch_target_predictor #(
        .ADDR_W(AW), .ENTRIES(16), .CTR_W(2), .STAT_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush_all(flush_all),
        .lookup_pc(lookup_pc), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_uncond(upd_uncond),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .stat_lookup_hits(stat_lookup_hits), .stat_mispredicts(stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    task automatic drive_upd(input logic [AW-1:0] pc, input logic unc, input logic tk,
                             input logic [AW-1:0] tgt, input logic ptk, input logic [AW-1:0] ppc);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_uncond     = unc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_pred_taken = ptk;
        upd_pred_pc    = ppc;
    endtask

    task automatic idle_upd();
        upd_valid = 1'b0; upd_pc = '0; upd_uncond = 1'b0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_pc = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL rst_redirect: got %0h want 0", redirect); end
        n_cmp++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL rst_redirect_pc: got %0h want 0", redirect_pc); end
        n_cmp++; if (stat_mispredicts !== 4'd0) begin n_err++; $display("FAIL rst_mispred: got %0d want 0", stat_mispredicts); end
        rst_n = 1'b1;
        lookup_pc = 32'h40;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rst_pred_taken: got %0h want 0", pred_taken); end
        n_cmp++; if (pred_pc !== 32'h44) begin n_err++; $display("FAIL rst_pred_pc: got %0h want 44", pred_pc); end
        @(negedge clk);
        lookup_pc = 32'h8;
        drive_upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
        @(posedge clk); #1;
        n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL pend_redirect: got %0h want 1", redirect); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL async_redirect: got %0h want 0", redirect); end
        n_cmp++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL async_redirect_pc: got %0h want 0", redirect_pc); end
        n_cmp++; if (stat_mispredicts !== 4'd0) begin n_err++; $display("FAIL async_mispred: got %0d want 0", stat_mispredicts); end
        n_cmp++; if (stat_lookup_hits !== 4'd0) begin n_err++; $display("FAIL async_hits: got %0d want 0", stat_lookup_hits); end
        @(negedge clk);
        idle_upd();
        rst_n = 1'b1;
        lookup_pc = 32'h40;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL async_table_clear: got %0h want 0", pred_taken); end
    endtask

    task automatic test_allocate();
        @(negedge clk);
        drive_upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL no_bypass: got %0h want 0", pred_taken); end
        @(posedge clk); #1;
        n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL alloc_redirect: got %0h want 1", redirect); end
        n_cmp++; if (redirect_pc !== 32'h100) begin n_err++; $display("FAIL alloc_redirect_pc: got %0h want 100", redirect_pc); end
        n_cmp++; if (stat_mispredicts !== 4'd1) begin n_err++; $display("FAIL alloc_mispred: got %0d want 1", stat_mispredicts); end
        @(negedge clk);
        idle_upd();
        #1;
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL alloc_hit: got %0h want 1", pred_taken); end
        n_cmp++; if (pred_pc !== 32'h100) begin n_err++; $display("FAIL alloc_pred_pc: got %0h want 100", pred_pc); end
        @(posedge clk); #1;
        n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL idle_redirect: got %0h want 0", redirect); end
        n_cmp++; if (redirect_pc !== 32'h100) begin n_err++; $display("FAIL idle_redirect_pc_hold: got %0h want 100", redirect_pc); end
    endtask

    task automatic test_counter();
        logic [AW-1:0] tgt   [7];
        logic          tk    [7];
        logic          unc   [7];
        logic          exp_t [7];
        logic [AW-1:0] exp_pc[7];
        tgt = '{32'h0, 32'h0, 32'h100, 32'h200, 32'h300, 32'h0, 32'h0};
        tk  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        unc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_t  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_pc = '{32'h44, 32'h44, 32'h44, 32'h200, 32'h300, 32'h300, 32'h44};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_upd(32'h40, unc[i], tk[i], tgt[i], 1'b0, 32'h44);
            @(posedge clk); #1;
            idle_upd();
            #1;
            n_cmp++; if (pred_taken !== exp_t[i]) begin n_err++; $display("FAIL ctr_step%0d_taken: got %0h want %0h", i, pred_taken, exp_t[i]); end
            n_cmp++; if (pred_pc !== exp_pc[i]) begin n_err++; $display("FAIL ctr_step%0d_pc: got %0h want %0h", i, pred_pc, exp_pc[i]); end
        end
    endtask

    task automatic test_alias();
        @(negedge clk);
        drive_upd(32'h440, 1'b0, 1'b1, 32'h500, 1'b0, 32'h444);
        @(posedge clk); #1;
        n_cmp++; if (redirect_pc !== 32'h500) begin n_err++; $display("FAIL alias_redirect_pc: got %0h want 500", redirect_pc); end
        @(negedge clk);
        idle_upd();
        lookup_pc = 32'h40;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_old_taken: got %0h want 0", pred_taken); end
        n_cmp++; if (pred_pc !== 32'h44) begin n_err++; $display("FAIL alias_old_pc: got %0h want 44", pred_pc); end
        lookup_pc = 32'h440;
        #1;
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL alias_new_taken: got %0h want 1", pred_taken); end
        n_cmp++; if (pred_pc !== 32'h500) begin n_err++; $display("FAIL alias_new_pc: got %0h want 500", pred_pc); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        flush_all = 1'b1;
        drive_upd(32'hC4, 1'b0, 1'b1, 32'h600, 1'b1, 32'h600);
        @(posedge clk); #1;
        n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL flush_correct_redirect: got %0h want 0", redirect); end
        @(negedge clk);
        idle_upd();
        flush_all = 1'b0;
        lookup_pc = 32'h440;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL flush_miss_440: got %0h want 0", pred_taken); end
        n_cmp++; if (pred_pc !== 32'h444) begin n_err++; $display("FAIL flush_pc_440: got %0h want 444", pred_pc); end
        lookup_pc = 32'hC4;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL flush_miss_c4: got %0h want 0", pred_taken); end
        @(negedge clk);
        flush_all = 1'b1;
        drive_upd(32'hC4, 1'b0, 1'b1, 32'h600, 1'b0, 32'hC8);
        @(posedge clk); #1;
        n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL flush_mis_redirect: got %0h want 1", redirect); end
        n_cmp++; if (redirect_pc !== 32'h600) begin n_err++; $display("FAIL flush_mis_redirect_pc: got %0h want 600", redirect_pc); end
        @(negedge clk);
        idle_upd();
        flush_all = 1'b0;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL flush_no_write: got %0h want 0", pred_taken); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        lookup_pc = 32'h8;
        drive_upd(32'h10, 1'b0, 1'b0, 32'h0, 1'b1, 32'h999);
        @(posedge clk); #1;
        n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL b2b_first: got %0h want 1", redirect); end
        n_cmp++; if (redirect_pc !== 32'h14) begin n_err++; $display("FAIL b2b_first_pc: got %0h want 14", redirect_pc); end
        @(negedge clk);
        drive_upd(32'h20, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        @(posedge clk); #1;
        n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL b2b_second: got %0h want 1", redirect); end
        n_cmp++; if (redirect_pc !== 32'h24) begin n_err++; $display("FAIL b2b_second_pc: got %0h want 24", redirect_pc); end
        @(negedge clk);
        idle_upd();
        @(posedge clk); #1;
        n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %0h want 0", redirect); end
        n_cmp++; if (redirect_pc !== 32'h24) begin n_err++; $display("FAIL b2b_end_pc: got %0h want 24", redirect_pc); end
    endtask

    task automatic test_stats_wrap();
        @(negedge clk);
        rst_n = 1'b0;
        lookup_pc = 32'h8;
        @(negedge clk);
        rst_n = 1'b1;
        drive_upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
        @(negedge clk);
        idle_upd();
        lookup_pc = 32'h40;
        repeat (14) @(posedge clk);
        #1;
        n_cmp++; if (stat_lookup_hits !== 4'd14) begin n_err++; $display("FAIL hits_14: got %0d want 14", stat_lookup_hits); end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (stat_lookup_hits !== 4'd15) begin n_err++; $display("FAIL hits_sat: got %0d want 15", stat_lookup_hits); end
        @(negedge clk);
        lookup_pc = 32'hFFFF_FFFC;
        drive_upd(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
        #1;
        n_cmp++; if (pred_pc !== 32'h0) begin n_err++; $display("FAIL lookup_wrap: got %0h want 0", pred_pc); end
        @(posedge clk); #1;
        n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL wrap_redirect: got %0h want 1", redirect); end
        n_cmp++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL wrap_redirect_pc: got %0h want 0", redirect_pc); end
        n_cmp++; if (stat_mispredicts !== 4'd2) begin n_err++; $display("FAIL mispred_2: got %0d want 2", stat_mispredicts); end
        repeat (15) @(posedge clk);
        #1;
        n_cmp++; if (stat_mispredicts !== 4'd15) begin n_err++; $display("FAIL mispred_sat: got %0d want 15", stat_mispredicts); end
        @(negedge clk);
        idle_upd();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush_all = 1'b0;
        lookup_pc = '0;
        idle_upd();
        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_flush();
        test_back_to_back();
        test_stats_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
